// File: rtl/ram_arbiter.sv
// Two-requester arbiter onto a simple dual-port RAM (write port A, read port B).
// Define RAM_ARB_RR_EN for a round-robin priority register; otherwise requester 0 wins conflicts.
module ram_arbiter #(
    parameter int AddrBusWidth = 5,
    parameter int DataBusWidth = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_we,
    input  logic [2*AddrBusWidth-1:0] req_addr,
    input  logic [2*DataBusWidth-1:0] req_wdata,
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_valid,
    output logic [DataBusWidth-1:0]   rsp_rdata,
    output logic [AddrBusWidth-1:0]   ram_addr_a,
    output logic                      ram_we_a,
    output logic [DataBusWidth-1:0]   ram_w_data_a,
    output logic [AddrBusWidth-1:0]   ram_addr_b,
    output logic                      ram_re_b,
    input  logic [DataBusWidth-1:0]   ram_r_data_b
);

    localparam int AW = AddrBusWidth;
    localparam int DW = DataBusWidth;

    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    grant;
    logic [1:0]    wr_go;
    logic [1:0]    rd_go;
    logic [1:0]    rd_owner;
    logic          prio;

    assign addr0  = req_addr[0*AW +: AW];
    assign addr1  = req_addr[1*AW +: AW];
    assign wdata0 = req_wdata[0*DW +: DW];
    assign wdata1 = req_wdata[1*DW +: DW];

`ifdef RAM_ARB_RR_EN
    logic prio_q;
    logic conflict;

    assign conflict = !rst && (&req_valid) && (req_we[0] == req_we[1]);
    assign prio     = prio_q;

    // After a conflict the loser gets priority next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (conflict) begin
            prio_q <= ~prio_q;
        end
    end
`else
    assign prio = 1'b0;
`endif

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (req_valid)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: begin
                    if (req_we[0] != req_we[1]) begin
                        // Same address: write first, the read retries.
                        if (addr0 == addr1) begin
                            grant = req_we;
                        end else begin
                            grant = 2'b11;
                        end
                    end else begin
                        grant = prio ? 2'b10 : 2'b01;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign wr_go     = grant & req_we;
    assign rd_go     = grant & ~req_we;

    always_comb begin
        ram_we_a     = 1'b0;
        ram_addr_a   = '0;
        ram_w_data_a = '0;
        if (wr_go[1]) begin
            ram_we_a     = 1'b1;
            ram_addr_a   = addr1;
            ram_w_data_a = wdata1;
        end else if (wr_go[0]) begin
            ram_we_a     = 1'b1;
            ram_addr_a   = addr0;
            ram_w_data_a = wdata0;
        end
    end

    always_comb begin
        ram_re_b   = 1'b0;
        ram_addr_b = '0;
        if (rd_go[1]) begin
            ram_re_b   = 1'b1;
            ram_addr_b = addr1;
        end else if (rd_go[0]) begin
            ram_re_b   = 1'b1;
            ram_addr_b = addr0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= 2'b00;
        end else begin
            rd_owner <= rd_go;
        end
    end

    assign rsp_valid = rd_owner;
    assign rsp_rdata = (|rd_owner) ? ram_r_data_b : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural sdpram on ports A/B.
// Expected grants come from a reference arbitration model; reads queue their data.
module tb_ram_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr_a;
    logic          ram_we_a;
    logic [DW-1:0] ram_w_data_a;
    logic [AW-1:0] ram_addr_b;
    logic          ram_re_b;
    logic [DW-1:0] ram_r_data_b;

    int total = 0;
    int bad = 0;
    logic [9:0]    sb_q[$];
    logic          exp_prio = 1'b0;
    logic [DW-1:0] shadow[32];
    logic [DW-1:0] mem[32];

    always #5 clk = ~clk;

    ram_arbiter #(.AddrBusWidth(AW), .DataBusWidth(DW)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ram_addr_a(ram_addr_a),
        .ram_we_a(ram_we_a),
        .ram_w_data_a(ram_w_data_a),
        .ram_addr_b(ram_addr_b),
        .ram_re_b(ram_re_b),
        .ram_r_data_b(ram_r_data_b)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 3);
            ram_r_data_b <= '0;
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_w_data_a;
            if (ram_re_b) ram_r_data_b <= mem[ram_addr_b];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_ready(input logic [1:0] v,
                                             input logic [1:0] we,
                                             input logic [AW-1:0] a0,
                                             input logic [AW-1:0] a1,
                                             input logic p);
        if (rst) return 2'b00;
        case (v)
            2'b01: return 2'b01;
            2'b10: return 2'b10;
            2'b11: begin
                if (we[0] ^ we[1]) return (a0 == a1) ? we : 2'b11;
                return p ? 2'b10 : 2'b01;
            end
            default: return 2'b00;
        endcase
    endfunction

    task automatic reinit_shadow();
        for (int i = 0; i < 32; i++) shadow[i] = 8'(i * 7 + 3);
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [1:0] r;
        logic [1:0] wa;
        logic [1:0] rd;
        logic [9:0] e;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        r  = exp_ready(v, we, a0, a1, exp_prio);
        wa = r & we;
        rd = r & ~we;
        check_eq("ready", 32'(req_ready), 32'(r));
        check_eq("we_a", 32'(ram_we_a), 32'(|wa));
        check_eq("addr_a", 32'(ram_addr_a),
                 32'(wa[1] ? a1 : (wa[0] ? a0 : 5'd0)));
        check_eq("wdata_a", 32'(ram_w_data_a),
                 32'(wa[1] ? d1 : (wa[0] ? d0 : 8'd0)));
        check_eq("re_b", 32'(ram_re_b), 32'(|rd));
        check_eq("addr_b", 32'(ram_addr_b),
                 32'(rd[1] ? a1 : (rd[0] ? a0 : 5'd0)));
        if (|rd) sb_q.push_back({rd, shadow[rd[1] ? a1 : a0]});
`ifdef RAM_ARB_RR_EN
        if (v == 2'b11 && we[0] == we[1]) exp_prio = ~exp_prio;
`endif
        if (wa[1]) shadow[a1] = d1;
        else if (wa[0]) shadow[a0] = d0;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("rsp_valid", 32'(rsp_valid), 32'(e[9:8]));
            check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
        end else begin
            check_eq("rsp_idle", 32'(rsp_valid), 32'(2'b00));
            check_eq("rsp_rdata0", 32'(rsp_rdata), 32'(8'h00));
        end
    endtask

    initial begin
        reinit_shadow();
        req_valid = 2'b11;
        req_we    = 2'b01;
        req_addr  = {5'd2, 5'd1};
        @(negedge clk);
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'(2'b00));
        check_eq("rst_we_a", 32'(ram_we_a), 32'(1'b0));
        check_eq("rst_re_b", 32'(ram_re_b), 32'(1'b0));
        check_eq("rst_rsp", 32'(rsp_valid), 32'(2'b00));
        check_eq("rst_rdata", 32'(rsp_rdata), 32'(8'h00));
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b0;

        step(2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00);
        step(2'b10, 2'b10, 5'h00, 5'h1B, 8'h00, 8'hC5);
        step(2'b01, 2'b00, 5'h1B, 5'h00, 8'h00, 8'h00);
        step(2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00);
        step(2'b01, 2'b01, 5'h04, 5'h00, 8'h77, 8'h00);
        step(2'b11, 2'b01, 5'h05, 5'h05, 8'hAA, 8'h00);
        step(2'b10, 2'b00, 5'h00, 5'h05, 8'h00, 8'h00);
        step(2'b11, 2'b01, 5'h03, 5'h04, 8'h11, 8'h00);
        step(2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++)
            step(2'b11, 2'b00, 5'h01, 5'h02, 8'h00, 8'h00);
        step(2'b11, 2'b11, 5'h06, 5'h07, 8'hD0, 8'hD1);
        step(2'b11, 2'b11, 5'h08, 5'h09, 8'hE0, 8'hE1);
        step(2'b01, 2'b00, 5'h06, 5'h00, 8'h00, 8'h00);
        step(2'b10, 2'b00, 5'h00, 5'h07, 8'h00, 8'h00);
        step(2'b01, 2'b00, 5'h08, 5'h00, 8'h00, 8'h00);
        step(2'b10, 2'b00, 5'h00, 5'h09, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++)
            step(2'b01, 2'b00, 5'(i), 5'h00, 8'h00, 8'h00);
        for (int i = 0; i < 80; i++)
            step(2'($urandom), 2'($urandom), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        step(2'b11, 2'b00, 5'h0C, 5'h0D, 8'h00, 8'h00);

        @(negedge clk);
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {5'h00, 5'h0A};
        #1;
        check_eq("pre_rst_ready", 32'(req_ready), 32'(2'b01));
        @(posedge clk);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_eq("arst_rsp", 32'(rsp_valid), 32'(2'b00));
        check_eq("arst_rdata", 32'(rsp_rdata), 32'(8'h00));
        check_eq("arst_re_b", 32'(ram_re_b), 32'(1'b0));
        check_eq("arst_ready", 32'(req_ready), 32'(2'b00));
        @(posedge clk);
        #1;
        check_eq("arst_rsp2", 32'(rsp_valid), 32'(2'b00));
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b0;
        exp_prio = 1'b0;
        reinit_shadow();
        step(2'b11, 2'b00, 5'h01, 5'h02, 8'h00, 8'h00);
        step(2'b11, 2'b00, 5'h03, 5'h04, 8'h00, 8'h00);
        step(2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
